// File: rtl/fetch.sv
// Instruction-fetch stage: PC generation, in-order imem requests, response FIFO and the ir register.
// Optional feature macro FETCH_MISALIGN_TRAP_EN adds fetch_fault for misaligned redirect targets.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);

    typedef logic [AW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        if (p == AW'(DEPTH - 1)) return '0;
        return p + AW'(1);
    endfunction

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    ptr_t          pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    ptr_t          fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [31:0]   ir_q, ir_d, ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;

    // The pending-PC queue occupancy always equals inflight, so it needs no own counter.
    logic [31:0]   pend_mem  [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];

    logic          accept, rsp_keep, rsp_drop, credit_ok, fault_block;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= |redirect_pc[1:0];
        end
    end

    assign fetch_fault = fault_q;
    assign fault_block = fault_q;
`else
    assign fault_block = 1'b0;
`endif

    assign credit_ok = ({2'b00, inflight_q} + {2'b00, drop_q} + {2'b00, fcnt_q}) < DEPTH_W;
    assign imem_req  = !reset && !redirect && !fault_block && credit_ok;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;
    assign rsp_drop  = imem_rvalid && (drop_q != '0);
    assign rsp_keep  = imem_rvalid && (drop_q == '0);

    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fcnt_d     = fcnt_q;
        pend_wr_d  = pend_wr_q;
        pend_rd_d  = pend_rd_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        if (redirect) begin
            // Low bits are dropped; a misaligned target is only acted on by the trap option.
            pc_d       = redirect_pc & ~32'h3;
            inflight_d = '0;
            // Whatever is still owed by memory must be discarded, less any response landing now.
            drop_d     = drop_q + inflight_q - CW'(imem_rvalid);
            fcnt_d     = '0;
            pend_wr_d  = '0;
            pend_rd_d  = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            ir_d       = NOP;
            ir_valid_d = 1'b0;
        end else begin
            if (accept) begin
                pc_d      = pc_q + 32'd4;
                pend_wr_d = ptr_inc(pend_wr_q);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                pend_rd_d = ptr_inc(pend_rd_q);
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end
            inflight_d = inflight_q + CW'(accept) - CW'(rsp_keep);
            fcnt_d     = fcnt_q + CW'(rsp_keep);
            if (!stall) begin
                if (fcnt_q != '0) begin
                    ir_d       = fifo_data[fifo_rd_q];
                    ir_pc_d    = fifo_pc[fifo_rd_q];
                    ir_valid_d = 1'b1;
                    fifo_rd_d  = ptr_inc(fifo_rd_q);
                    fcnt_d     = fcnt_q + CW'(rsp_keep) - CW'(1);
                end else begin
                    ir_d       = NOP;
                    ir_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            fcnt_q     <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            ir_q       <= NOP;
            ir_pc_q    <= RESET_PC;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fcnt_q     <= fcnt_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // Storage arrays carry no reset; pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_mem[pend_wr_q] <= pc_q;
        end
        if (!redirect && rsp_keep) begin
            fifo_data[fifo_wr_q] <= imem_rdata;
            fifo_pc[fifo_wr_q]   <= pend_mem[pend_rd_q];
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order memory model, directed cycle checks and an ir_pc/ir scoreboard.
// Built with FETCH_MISALIGN_TRAP_EN it also covers the misaligned-redirect trap.
module tb_fetch;

    // Three credits let a 1-cycle memory stream one word per cycle.
    localparam int unsigned DEPTH = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] ir, ir_pc;
    logic        ir_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    logic        rsp_en;
    logic [31:0] mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH),
        .NOP     (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault(fetch_fault)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: in-order, 1-cycle minimum latency, responses held back while rsp_en=0.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_rvalid) void'(mq.pop_front());
            if (imem_req && imem_ready) mq.push_back(imem_addr);
            if (rsp_en && mq.size() > 0) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_word(mq[0]);
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    // Monitor: decode consumes ir on every non-stalled, non-redirect cycle.
    always @(negedge clk) begin
        if (!reset && ir_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_extra: got ir_pc %h, none expected", ir_pc);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_ir_pc", ir_pc, sb_e);
                chk("sb_ir", ir, mem_word(sb_e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            smp();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b0; rsp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        smp();
        chk("rst_ir", ir, NOP);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // Memory not ready for 3 cycles: request held at 0x0.
        tick(); reset = 1'b0; smp();
        chk("hold_req0", 32'(imem_req), 32'd1);
        chk("hold_addr0", imem_addr, 32'h0);
        chk("hold_ir_valid0", 32'(ir_valid), 32'd0);
        tick(); smp();
        chk("hold_addr1", imem_addr, 32'h0);
        tick(); smp();
        chk("hold_req2", 32'(imem_req), 32'd1);
        chk("hold_addr2", imem_addr, 32'h0);

        // Stream: 0x0, 0x4, 0x8 on consecutive cycles.
        tick(); imem_ready = 1'b1;
        exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h08);
        exp_q.push_back(32'h0C); exp_q.push_back(32'h10); exp_q.push_back(32'h14);
        smp();
        chk("stream_addr0", imem_addr, 32'h0);
        tick(); smp();
        chk("stream_addr4", imem_addr, 32'h4);
        tick(); smp();
        chk("stream_addr8", imem_addr, 32'h8);
        chk("stream_not_yet_valid", 32'(ir_valid), 32'd0);

        // Stall 4 cycles while memory keeps streaming.
        tick(); stall = 1'b1; smp();
        chk("first_ir_valid", 32'(ir_valid), 32'd1);
        chk("first_ir_pc", ir_pc, 32'h0);
        chk("stall_addr12", imem_addr, 32'h0C);
        tick(); smp();
        chk("stall_req_off1", 32'(imem_req), 32'd0);
        chk("stall_ir_pc1", ir_pc, 32'h0);
        tick(); smp();
        chk("stall_req_off2", 32'(imem_req), 32'd0);
        chk("stall_ir1", ir, mem_word(32'h0));
        tick(); smp();
        chk("stall_ir_pc3", ir_pc, 32'h0);
        tick(); stall = 1'b0; smp();
        chk("release_ir_pc", ir_pc, 32'h0);
        tick(); smp();
        chk("release_ir_pc4", ir_pc, 32'h4);
        chk("release_addr16", imem_addr, 32'h10);
        tick(); smp();
        chk("release_ir_pc8", ir_pc, 32'h8);
        tick(); imem_ready = 1'b0; smp();
        chk("release_ir_pc12", ir_pc, 32'h0C);
        idle(4);
        chk("drain1_ir_valid", 32'(ir_valid), 32'd0);
        chk("drain1_addr", imem_addr, 32'h18);

        // Redirect to 0x100 with two words in flight.
        tick(); imem_ready = 1'b1; rsp_en = 1'b0; smp();
        chk("rd_addr24", imem_addr, 32'h18);
        tick(); smp();
        chk("rd_addr28", imem_addr, 32'h1C);
        tick(); redirect = 1'b1; redirect_pc = 32'h100; smp();
        chk("rd_req_off", 32'(imem_req), 32'd0);
        tick(); redirect = 1'b0; rsp_en = 1'b1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
        smp();
        chk("rd_ir_valid0", 32'(ir_valid), 32'd0);
        chk("rd_req_new", 32'(imem_req), 32'd1);
        chk("rd_addr_new", imem_addr, 32'h100);
        tick(); smp();
        chk("rd_credit_block", 32'(imem_req), 32'd0);
        tick(); smp();
        chk("rd_addr104", imem_addr, 32'h104);
        tick(); smp();
        chk("rd_addr108", imem_addr, 32'h108);
        tick(); imem_ready = 1'b0; smp();
        tick(); smp();
        chk("rd_first_ir_pc", ir_pc, 32'h100);
        idle(4);

        // Redirect together with stall, plus PC wrap.
        tick(); imem_ready = 1'b1; smp();
        chk("ws_addr10c", imem_addr, 32'h10C);
        tick(); smp();
        tick(); smp();
        tick(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; smp();
        chk("ws_held_valid", 32'(ir_valid), 32'd1);
        chk("ws_req_off", 32'(imem_req), 32'd0);
        tick(); stall = 1'b0; redirect = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        smp();
        chk("ws_ir_nop", ir, NOP);
        chk("ws_ir_valid", 32'(ir_valid), 32'd0);
        chk("ws_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(); smp();
        chk("ws_addr_wrap", imem_addr, 32'h0);
        tick(); imem_ready = 1'b0; smp();
        idle(4);

`ifdef FETCH_MISALIGN_TRAP_EN
        tick(); redirect = 1'b1; redirect_pc = 32'h102; smp();
        tick(); redirect = 1'b0; smp();
        chk("mis_fault_set", 32'(fetch_fault), 32'd1);
        chk("mis_req_off", 32'(imem_req), 32'd0);
        tick(); smp();
        chk("mis_req_held", 32'(imem_req), 32'd0);
        chk("mis_ir_valid", 32'(ir_valid), 32'd0);
        tick(); redirect = 1'b1; redirect_pc = 32'h200; smp();
        tick(); redirect = 1'b0; smp();
        chk("mis_fault_clr", 32'(fetch_fault), 32'd0);
        chk("mis_req_on", 32'(imem_req), 32'd1);
        chk("mis_addr200", imem_addr, 32'h200);
`else
        tick(); redirect = 1'b1; redirect_pc = 32'h202; smp();
        tick(); redirect = 1'b0; smp();
        chk("lowbits_req", 32'(imem_req), 32'd1);
        chk("lowbits_addr", imem_addr, 32'h200);
`endif
        idle(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
